// File: rtl/rx_frame_store.sv
// Receive frame store: circular byte RAM, commits good frames, rewinds bad ones; RX_STATS_EN adds counters.
// Latency: rd_valid one cycle after an accepted rd_req; drop reported one cycle after the closing event.
// Backpressure: none on the receive side (overflow drops the frame); host paces reads with rd_req.
module rx_frame_store #(
  parameter int ADDR_W  = 9,
  parameter int LQ_W    = 2,
  parameter int MIN_LEN = 3
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              byte_ready,
  input  logic [7:0]        din,
  input  logic              frame_complete,
  input  logic              frame_valid,
  input  logic              abort,
  input  logic              rd_req,
  output logic [7:0]        rd_data,
  output logic              rd_valid,
  output logic              rd_last,
  output logic              frame_avail,
  output logic [ADDR_W:0]   frame_len,
  output logic              drop,
  output logic [1:0]        drop_code
`ifdef RX_STATS_EN
  ,
  input  logic              stat_clr,
  output logic [15:0]       stat_good,
  output logic [15:0]       stat_crc,
  output logic [15:0]       stat_abort,
  output logic [15:0]       stat_ovf,
  output logic [15:0]       stat_runt
`endif
);

  localparam int DEPTH    = 1 << ADDR_W;
  localparam int LQ_DEPTH = 1 << LQ_W;

  localparam logic [ADDR_W:0] PTR_ONE   = (ADDR_W+1)'(1);
  localparam logic [ADDR_W:0] PTR_ZERO  = '0;
  localparam logic [ADDR_W:0] DEPTH_W   = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] MIN_LEN_W = (ADDR_W+1)'(MIN_LEN);
  localparam logic [LQ_W:0]   LQ_ONE    = (LQ_W+1)'(1);
  localparam logic [LQ_W:0]   LQ_FULL   = (LQ_W+1)'(LQ_DEPTH);

  localparam logic [1:0] DC_CRC   = 2'd0;
  localparam logic [1:0] DC_ABORT = 2'd1;
  localparam logic [1:0] DC_OVF   = 2'd2;
  localparam logic [1:0] DC_RUNT  = 2'd3;

  typedef enum logic [1:0] {IDLE = 2'd0, RECV = 2'd1, DROP = 2'd2} wstate_t;

  wstate_t         state, state_n;
  logic [ADDR_W:0] wr_start, wr_ptr, wr_ptr_n, rd_ptr, rd_cnt;
  logic [ADDR_W:0] used, len_now, lq_head;
  logic            full;
  logic            wr_en, close, rewind, commit, drop_n;
  logic [1:0]      code_n;
  logic            rd_go, rd_end;
  logic [7:0]      ram_q;

  logic [7:0]      ram    [DEPTH];
  logic [ADDR_W:0] lq_mem [LQ_DEPTH];
  logic [LQ_W:0]   lq_wp, lq_rp;
  logic            lq_full;

  // Occupancy from registered pointers only; committed and in-progress regions never overlap.
  assign used    = wr_ptr - rd_ptr;
  assign full    = (used == DEPTH_W);
  assign lq_full = ((lq_wp - lq_rp) == LQ_FULL);
  assign lq_head = lq_mem[lq_rp[LQ_W-1:0]];

  assign frame_avail = (lq_wp != lq_rp);
  assign frame_len   = frame_avail ? lq_head : PTR_ZERO;

  assign rd_go   = rd_req && frame_avail;
  assign rd_end  = rd_go && ((rd_cnt + PTR_ONE) == lq_head);
  assign rd_data = rd_valid ? ram_q : 8'h00;

  always_comb begin
    wr_en   = 1'b0;
    close   = 1'b0;
    rewind  = 1'b0;
    commit  = 1'b0;
    drop_n  = 1'b0;
    code_n  = DC_CRC;
    state_n = state;
    len_now = PTR_ZERO;
    case (state)
      IDLE: begin
        // A byte together with the closing flag forms a one-byte frame, not an empty one.
        if (!abort && byte_ready) begin
          if (full) begin
            if (frame_complete) begin
              drop_n = 1'b1;
              code_n = DC_OVF;
            end else begin
              state_n = DROP;
            end
          end else begin
            wr_en = 1'b1;
            if (frame_complete) close = 1'b1;
            else                state_n = RECV;
          end
        end
      end
      RECV: begin
        if (abort) begin
          rewind  = 1'b1;
          drop_n  = 1'b1;
          code_n  = DC_ABORT;
          state_n = IDLE;
        end else if (byte_ready && full) begin
          if (frame_complete) begin
            rewind  = 1'b1;
            drop_n  = 1'b1;
            code_n  = DC_OVF;
            state_n = IDLE;
          end else begin
            state_n = DROP;
          end
        end else begin
          wr_en = byte_ready;
          close = frame_complete;
        end
      end
      DROP: begin
        if (abort || frame_complete) begin
          rewind  = 1'b1;
          drop_n  = 1'b1;
          code_n  = DC_OVF;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase

    len_now = wr_ptr - wr_start + (wr_en ? PTR_ONE : PTR_ZERO);
    if (close) begin
      state_n = IDLE;
      if (!frame_valid) begin
        rewind = 1'b1;
        drop_n = 1'b1;
        code_n = DC_CRC;
      end else if ((len_now < MIN_LEN_W) || lq_full) begin
        rewind = 1'b1;
        drop_n = 1'b1;
        code_n = DC_RUNT;
      end else begin
        commit = 1'b1;
      end
    end

    wr_ptr_n = rewind ? wr_start : (wr_en ? wr_ptr + PTR_ONE : wr_ptr);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      wr_ptr    <= PTR_ZERO;
      wr_start  <= PTR_ZERO;
      rd_ptr    <= PTR_ZERO;
      rd_cnt    <= PTR_ZERO;
      lq_wp     <= '0;
      lq_rp     <= '0;
      rd_valid  <= 1'b0;
      rd_last   <= 1'b0;
      drop      <= 1'b0;
      drop_code <= DC_CRC;
    end else begin
      state     <= state_n;
      wr_ptr    <= wr_ptr_n;
      drop      <= drop_n;
      drop_code <= drop_n ? code_n : DC_CRC;
      rd_valid  <= rd_go;
      rd_last   <= rd_end;
      if (commit) begin
        wr_start <= wr_ptr_n;
        lq_wp    <= lq_wp + LQ_ONE;
      end
      if (rd_go) begin
        rd_ptr <= rd_ptr + PTR_ONE;
        rd_cnt <= rd_end ? PTR_ZERO : rd_cnt + PTR_ONE;
      end
      if (rd_end) lq_rp <= lq_rp + LQ_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) ram[wr_ptr[ADDR_W-1:0]] <= din;
    if (rd_go) ram_q <= ram[rd_ptr[ADDR_W-1:0]];
  end

  always_ff @(posedge clk) begin
    if (commit) lq_mem[lq_wp[LQ_W-1:0]] <= len_now;
  end

`ifdef RX_STATS_EN
  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stat_good  <= 16'd0;
      stat_crc   <= 16'd0;
      stat_abort <= 16'd0;
      stat_ovf   <= 16'd0;
      stat_runt  <= 16'd0;
    end else if (stat_clr) begin
      stat_good  <= 16'd0;
      stat_crc   <= 16'd0;
      stat_abort <= 16'd0;
      stat_ovf   <= 16'd0;
      stat_runt  <= 16'd0;
    end else begin
      if (commit)                         stat_good  <= sat_inc(stat_good);
      if (drop_n && (code_n == DC_CRC))   stat_crc   <= sat_inc(stat_crc);
      if (drop_n && (code_n == DC_ABORT)) stat_abort <= sat_inc(stat_abort);
      if (drop_n && (code_n == DC_OVF))   stat_ovf   <= sat_inc(stat_ovf);
      if (drop_n && (code_n == DC_RUNT))  stat_runt  <= sat_inc(stat_runt);
    end
  end
`endif

endmodule

// File: doc/rx_frame_store.md
Name: rx_frame_store

Overview:
- Downstream of the receive deframer/top. Consumes per-byte strobes plus frame-complete/valid/abort indications, already retimed into the system clock domain as single-cycle pulses.
- Stores received Econet frames in a circular byte RAM and commits only frames that are CRC-good, non-runt and non-overflowed.
- Presents committed frames to the host/bridge logic through a byte-read handshake with per-frame length.
- Bad, aborted or overflowed frames are rewound out of the buffer.

Parameters:
- ADDR_W, 9: byte RAM address width; DEPTH = 2**ADDR_W bytes.
- LQ_W, 2: length-queue address width; holds up to 2**LQ_W committed frames.
- MIN_LEN, 3: minimum committed frame length in bytes, FCS included; shorter frames are runts.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- byte_ready  in  1  one-cycle strobe: din holds a received byte
- din  in  8  received byte
- frame_complete  in  1  one-cycle pulse: closing flag seen
- frame_valid  in  1  CRC-good level, sampled only when frame_complete=1
- abort  in  1  one-cycle pulse: abort sequence seen
- rd_req  in  1  host requests next byte of head frame
- rd_data  out  8  byte read from RAM
- rd_valid  out  1  rd_data valid (one cycle)
- rd_last  out  1  qualifies rd_valid: final byte of frame
- frame_avail  out  1  at least one committed frame queued
- frame_len  out  ADDR_W+1  length of head frame; valid while frame_avail=1
- drop  out  1  one-cycle pulse: a frame was discarded
- drop_code  out  2  reason, valid with drop: 0 CRC bad, 1 abort, 2 overflow, 3 runt or queue full

Behaviour:
- Reset: all pointers, counters and queue cleared, write FSM=IDLE; every output 0.
- Pointers: wr_start (start of frame being received), wr_ptr, rd_ptr. All are ADDR_W+1 bits with a wrap bit.
  - used = wr_ptr - rd_ptr, modulo 2**(ADDR_W+1).
  - full when used == DEPTH.
- Write FSM, states IDLE, RECV, DROP:
  - IDLE: byte_ready writes din at wr_ptr, wr_ptr++, go RECV.
  - RECV: byte_ready writes and increments. If byte_ready arrives while full, no write; go DROP.
  - DROP: ignore bytes; on frame_complete or abort, wr_ptr<=wr_start, drop code 2, go IDLE.
  - frame_complete in RECV, with len = wr_ptr - wr_start:
    - frame_valid=0: rewind wr_ptr to wr_start, drop code 0.
    - else len<MIN_LEN: rewind, drop code 3.
    - else length queue full: rewind, drop code 3.
    - else push len, wr_start<=wr_ptr. Go IDLE.
  - abort in RECV: rewind, drop code 1, go IDLE. abort in IDLE: no effect, no drop.
  - frame_complete in IDLE (empty frame): ignored, no drop.
- Simultaneous events:
  - byte_ready with frame_complete: the byte is written first and counted in len.
  - abort with frame_complete: abort wins.
  - abort with byte_ready: byte discarded with the frame.
- Read side:
  - frame_avail = queue not empty; frame_len = queue head.
  - rd_req when frame_avail=1: RAM read at rd_ptr, rd_ptr++, internal count++. rd_valid asserts next cycle (latency 1).
  - At the byte where count == frame_len: rd_last=1 with rd_valid, queue pops, count<=0. frame_avail deasserts in that same cycle if the queue is now empty.
  - rd_req when frame_avail=0: ignored.
  - rd_req may be held high back-to-back: one byte per cycle.
  - Issuing the request after the last byte is allowed and starts the next frame with no bubble.
- Read and write may occur in the same cycle. used is computed from the registered pointers; the read of committed bytes never touches the uncommitted region.
- Single-port read / single-port write RAM, write-first is not required since regions never overlap.

Optional Feature:
- RX_STATS_EN defined: adds outputs stat_good, stat_crc, stat_abort, stat_ovf, stat_runt, each 16 bits. Each increments on the matching commit or drop, saturating at 16'hFFFF. All clear on reset, and all clear synchronously when input stat_clr=1. stat_clr takes priority over a same-cycle increment.
- RX_STATS_EN undefined: these ports and registers are absent; behaviour is otherwise identical.

Test Plan:
- 6 bytes 01..06, then frame_complete with frame_valid=1 -> frame_avail=1, frame_len=6. Hold rd_req 6 cycles -> rd_data 01..06 one cycle later each, rd_last on 06, frame_avail=0.
- 5 bytes, then frame_complete with frame_valid=0 -> drop=1, drop_code=0, frame_avail stays 0, used returns to 0.
- 3 bytes, then abort in the same cycle as a 4th byte_ready -> drop_code=1. A next good 4-byte frame reads back from the rewound address with correct data.
- ADDR_W=4: 17-byte frame with no reads -> drop_code=2 only at frame_complete; a following 4-byte frame commits.
- 2-byte good frame -> drop_code=3. With 4 frames queued, a 5th good frame -> drop_code=3 and the first 4 frames read back intact.
- Reset asserted mid-frame and mid-read -> all outputs 0 next cycle. A new frame after release is stored from address 0.
